// File: rtl/adc_scan_ctrl.sv
// Scan sequencer for the 8-bit SAR ADC: walks a masked channel set, settles, converts, stores.
// Define ADC_AVG4_EN to convert each channel four times and store the truncated mean.
module adc_scan_ctrl #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned TIMEOUT_CYC = 64,
    localparam int unsigned CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           cont,
    input  logic [NCH-1:0] ch_mask,
    output logic           soc,
    input  logic           eoc,
    input  logic [7:0]     adc_data,
    output logic           adc_ena,
    output logic [CW-1:0]  ch_sel,
    output logic           res_valid,
    output logic [CW-1:0]  res_ch,
    output logic [7:0]     res_data,
    input  logic [CW-1:0]  rd_ch,
    output logic [7:0]     rd_data,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {StIdle, StSettle, StConv, StWait, StStore} state_e;

    state_e         state_q, state_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [CW-1:0]  ch_sel_q, ch_sel_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           eoc_q;
    logic           soc_q, soc_d;
    logic           ena_q, ena_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           res_valid_q, res_valid_d;
    logic [CW-1:0]  res_ch_q, res_ch_d;
    logic [7:0]     res_data_q, res_data_d;
    logic [7:0]     regs_q [NCH];

    logic           eoc_rise;
    logic           advance;
    logic           wr_en;
    logic           next_found;
    logic [CW-1:0]  next_ch;
    logic           conv_last;
    logic [7:0]     conv_val;

`ifdef ADC_AVG4_EN
    logic [1:0]     idx_q, idx_d;
    logic [9:0]     acc_q, acc_d;
    logic [9:0]     acc_sum;

    assign acc_sum   = acc_q + {2'b00, adc_data};
    assign conv_last = (idx_q == 2'd3);
    assign conv_val  = acc_sum[9:2];
`else
    assign conv_last = 1'b1;
    assign conv_val  = adc_data;
`endif

    // Only a genuine low-to-high transition completes; a level left over never does.
    assign eoc_rise = eoc & ~eoc_q;

    function automatic logic [CW-1:0] lowest_set(input logic [NCH-1:0] m);
        lowest_set = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = CW'(i);
        end
    endfunction

    always_comb begin
        next_found = 1'b0;
        next_ch    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_sel_q))) begin
                next_found = 1'b1;
                next_ch    = CW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ch_sel_d    = ch_sel_q;
        settle_d    = settle_q;
        timer_d     = timer_q;
        err_d       = err_q;
        done_d      = 1'b0;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        wr_en       = 1'b0;
        advance     = 1'b0;
`ifdef ADC_AVG4_EN
        idx_d       = idx_q;
        acc_d       = acc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start && (ch_mask != '0)) begin
                    mask_d   = ch_mask;
                    err_d    = 1'b0;
                    ch_sel_d = lowest_set(ch_mask);
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
`ifdef ADC_AVG4_EN
                idx_d = '0;
                acc_d = '0;
`endif
                if (settle_q == SW'(SETTLE_CYC - 1)) begin
                    state_d = StConv;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StConv: begin
                // Timer holds the number of cycles elapsed since soc.
                timer_d = TW'(1);
                state_d = StWait;
            end
            StWait: begin
                if (eoc_rise) begin
`ifdef ADC_AVG4_EN
                    acc_d = acc_sum;
                    idx_d = idx_q + 2'd1;
`endif
                    if (conv_last) begin
                        state_d     = StStore;
                        res_valid_d = 1'b1;
                        res_ch_d    = ch_sel_q;
                        res_data_d  = conv_val;
                        wr_en       = 1'b1;
                    end else begin
                        state_d = StConv;
                    end
                end else if (timer_q >= TW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    advance = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StStore: advance = 1'b1;
            default: state_d = StIdle;
        endcase

        if (advance) begin
            settle_d = '0;
            if (next_found) begin
                ch_sel_d = next_ch;
                state_d  = StSettle;
            end else if (cont) begin
                ch_sel_d = lowest_set(mask_q);
                state_d  = StSettle;
            end else begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end
    end

    // Handshake outputs come straight from flops so soc cannot glitch.
    assign soc_d = (state_d == StConv);
    assign ena_d = (state_d != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            ch_sel_q    <= '0;
            settle_q    <= '0;
            timer_q     <= '0;
            eoc_q       <= 1'b0;
            soc_q       <= 1'b0;
            ena_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            for (int i = 0; i < NCH; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ch_sel_q    <= ch_sel_d;
            settle_q    <= settle_d;
            timer_q     <= timer_d;
            eoc_q       <= eoc;
            soc_q       <= soc_d;
            ena_q       <= ena_d;
            done_q      <= done_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            if (wr_en) regs_q[ch_sel_q] <= conv_val;
        end
    end

`ifdef ADC_AVG4_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end
`endif

    assign soc       = soc_q;
    assign adc_ena   = ena_q;
    assign busy      = ena_q;
    assign ch_sel    = ch_sel_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_data   = (int'(rd_ch) < int'(NCH)) ? regs_q[rd_ch] : 8'h00;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Randomized bench for adc_scan_ctrl: SAR model, output monitor and a channel-list reference model.
module tb_adc_scan_ctrl;

    localparam int NCH     = 4;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 64;
`ifdef ADC_AVG4_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif

    logic       clk, rst_n, start, cont, soc, eoc, adc_ena, res_valid, busy, done, err;
    logic [3:0] ch_mask;
    logic [7:0] adc_data, res_data, rd_data;
    logic [1:0] ch_sel, res_ch, rd_ch;

    adc_scan_ctrl #(
        .NCH         (NCH),
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cont      (cont),
        .ch_mask   (ch_mask),
        .soc       (soc),
        .eoc       (eoc),
        .adc_data  (adc_data),
        .adc_ena   (adc_ena),
        .ch_sel    (ch_sel),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_data  (res_data),
        .rd_ch     (rd_ch),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;

    int mon_res_ch [$];
    int mon_res_data [$];
    int mon_soc_n, mon_done_n, mon_busy_n;
    int mon_soc_first, mon_res_first, mon_err_first;

    int         sar_delay = 10;
    bit         sar_hang  = 1'b0;
    int         sar_mode  = 1;
    int         sar_ramp  = 0;
    int         sar_cnt   = -1;
    int         sar_cur_ch = 0;
    logic [7:0] sar_tab [4];
    int         sar_log_ch [$];
    int         sar_log_data [$];
    logic [7:0] exp_regs [4];
    int         exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SAR model: eoc drops on soc and rises sar_delay cycles later with a fresh sample.
    initial begin
        logic [7:0] d;
        eoc      = 1'b0;
        adc_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                eoc     = 1'b0;
                sar_cnt = -1;
            end else if (soc) begin
                eoc        = 1'b0;
                sar_cnt    = sar_delay;
                sar_cur_ch = int'(ch_sel);
            end else if (sar_cnt > 0) begin
                sar_cnt--;
                if (sar_cnt == 0 && !(sar_hang && sar_cur_ch == 1)) begin
                    case (sar_mode)
                        0:       d = 8'($urandom);
                        1:       d = sar_tab[sar_cur_ch];
                        default: begin
                            d = 8'(8'h10 + sar_ramp);
                            sar_ramp++;
                        end
                    endcase
                    adc_data = d;
                    eoc      = 1'b1;
                    sar_log_ch.push_back(sar_cur_ch);
                    sar_log_data.push_back(int'(d));
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (res_valid) begin
                mon_res_ch.push_back(int'(res_ch));
                mon_res_data.push_back(int'(res_data));
                if (mon_res_first < 0) mon_res_first = cyc;
            end
            if (soc) begin
                if (mon_soc_first < 0) mon_soc_first = cyc;
                mon_soc_n++;
            end
            if (done) mon_done_n++;
            if (busy) mon_busy_n++;
            if (err && mon_err_first < 0) mon_err_first = cyc;
        end
    end

    task automatic clear_mon();
        mon_res_ch.delete();
        mon_res_data.delete();
        sar_log_ch.delete();
        sar_log_data.delete();
        mon_soc_n     = 0;
        mon_done_n    = 0;
        mon_busy_n    = 0;
        mon_soc_first = -1;
        mon_res_first = -1;
        mon_err_first = -1;
    endtask

    task automatic pulse_start(input logic [3:0] m);
        @(negedge clk);
        start     = 1'b1;
        ch_mask   = m;
        start_cyc = cyc;
        @(negedge clk);
        start   = 1'b0;
        ch_mask = 4'($urandom);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mon_done_n != 0) break;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_regs();
        for (int c = 0; c < NCH; c++) begin
            rd_ch = 2'(c);
            #1;
            check_eq($sformatf("rd_data%0d", c), rd_data, exp_regs[c]);
        end
    endtask

    // Expected result k: channel exp_ch[k], value = floor(mean of its NCONV samples).
    task automatic check_results(input int exp_ch [$]);
        check_eq("nres", mon_res_ch.size(), exp_ch.size());
        for (int k = 0; k < exp_ch.size(); k++) begin
            int sum = 0;
            logic [7:0] exp_d;
            for (int j = 0; j < NCONV; j++) begin
                int idx = k * NCONV + j;
                if (idx < sar_log_data.size()) begin
                    sum += sar_log_data[idx];
                    check_eq($sformatf("sar_ch%0d", idx), sar_log_ch[idx], exp_ch[k]);
                end
            end
            exp_d = 8'(sum / NCONV);
            if (k < mon_res_ch.size()) begin
                check_eq($sformatf("res_ch%0d", k), mon_res_ch[k], exp_ch[k]);
                check_eq($sformatf("res_data%0d", k), mon_res_data[k], exp_d);
            end
            exp_regs[exp_ch[k]] = exp_d;
        end
        check_regs();
    endtask

    task automatic run_scan(input logic [3:0] m, input int delay);
        clear_mon();
        sar_delay = delay;
        cont      = 1'b0;
        pulse_start(m);
        wait_done(4000);
        exp_q.delete();
        for (int c = 0; c < NCH; c++) if (m[c]) exp_q.push_back(c);
        check_results(exp_q);
        check_eq("ndone", mon_done_n, 1);
        check_eq("nsoc", mon_soc_n, exp_q.size() * NCONV);
        check_eq("soc_lat", mon_soc_first - start_cyc, SETTLE + 1);
        check_eq("res_lat", mon_res_first - mon_soc_first, NCONV * (delay + 1));
        check_eq("ena_off", adc_ena, 1'b0);
        check_eq("busy_off", busy, 1'b0);
    endtask

    initial begin
        start   = 1'b0;
        cont    = 1'b0;
        ch_mask = 4'h0;
        rd_ch   = 2'd0;
        rst_n   = 1'b1;
        sar_tab[0] = 8'h3A;
        sar_tab[1] = 8'h5B;
        sar_tab[2] = 8'hC5;
        sar_tab[3] = 8'h81;
        for (int c = 0; c < NCH; c++) exp_regs[c] = 8'h00;
        clear_mon();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_eq("rst_soc", soc, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_res_valid", res_valid, 1'b0);
        check_eq("rst_ena", adc_ena, 1'b0);
        check_eq("rst_ch_sel", ch_sel, 2'd0);
        check_eq("rst_res_data", res_data, 8'h00);
        check_regs();

        // Two-channel single pass with fixed sample values.
        sar_mode = 1;
        run_scan(4'b0101, 10);
        rd_ch = 2'd0;
        #1 check_eq("t1_rd0", rd_data, 8'h3A);
        rd_ch = 2'd2;
        #1 check_eq("t1_rd2", rd_data, 8'hC5);

        // Empty mask is ignored.
        clear_mon();
        pulse_start(4'b0000);
        repeat (50) @(negedge clk);
        check_eq("t2_busy", mon_busy_n, 0);
        check_eq("t2_soc", mon_soc_n, 0);
        check_eq("t2_done", mon_done_n, 0);
        check_eq("t2_err", err, 1'b0);

        // Conversion that never completes.
        sar_hang = 1'b1;
        clear_mon();
        sar_delay = 10;
        pulse_start(4'b0010);
        wait_done(500);
        check_eq("t3_err_lat", mon_err_first - mon_soc_first, TIMEOUT);
        check_eq("t3_nres", mon_res_ch.size(), 0);
        check_eq("t3_nsoc", mon_soc_n, 1);
        check_eq("t3_done", mon_done_n, 1);
        check_eq("t3_ena", adc_ena, 1'b0);
        check_eq("t3_err", err, 1'b1);
        sar_hang = 1'b0;

        // Continuous mode, cont dropped during the second pass's first channel.
        sar_mode = 0;
        clear_mon();
        sar_delay = 6;
        cont = 1'b1;
        pulse_start(4'b1001);
        check_eq("t4_err_clr", err, 1'b0);
        for (int i = 0; i < 2000 && mon_res_ch.size() < 2; i++) @(negedge clk);
        for (int i = 0; i < 200 && ch_sel != 2'd0; i++) @(negedge clk);
        cont = 1'b0;
        wait_done(3000);
        exp_q = {0, 3, 0, 3};
        check_results(exp_q);
        check_eq("t4_done", mon_done_n, 1);

        // Reset while waiting for eoc.
        sar_mode = 1;
        clear_mon();
        sar_delay = 10;
        pulse_start(4'b0001);
        for (int i = 0; i < 100 && mon_soc_n < 1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t5_soc", soc, 1'b0);
        check_eq("t5_busy", busy, 1'b0);
        check_eq("t5_ena", adc_ena, 1'b0);
        check_eq("t5_res_valid", res_valid, 1'b0);
        for (int c = 0; c < NCH; c++) exp_regs[c] = 8'h00;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_scan(4'b0110, 7);

`ifdef ADC_AVG4_EN
        sar_mode = 2;
        sar_ramp = 0;
        run_scan(4'b0001, 5);
        rd_ch = 2'd0;
        #1 check_eq("t6_avg", rd_data, 8'h11);
`endif

        sar_mode = 0;
        for (int it = 0; it < 10; it++) begin
            run_scan(4'($urandom_range(1, 15)), int'($urandom_range(2, 40)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
